router_reg: RTL and testbench
=============================

// Module: router_reg
// PURPOSE
//  Datapath register block of the 1x3 packet router, between the input port and the three output FIFOs.
//  Registers header, payload and parity bytes toward the FIFO write port (dout) under FSM state strobes.
//  Holds a byte that arrives while the FIFO is full, and replays it later.
//  Accumulates even (XOR) parity, compares it with the packet parity byte, and flags mismatch on err.
// PARAMETERS
//  DATA_WIDTH  8  byte width of data_in/dout/parity registers
//  ADDR_BITS   2  header LSBs carrying destination address
// PORTS
//  clock          in   1   single clock; all state updates on posedge
//  resetn         in   1   synchronous, active-high reset (1 = reset on posedge clock)
//  pkt_valid      in   1   input byte valid; drops at parity byte
//  data_in        in   8   packet byte: header, payload or parity
//  fifo_full      in   1   addressed FIFO full
//  rst_int_reg    in   1   FSM request to clear low_pkt_valid
//  detect_add     in   1   FSM DECODE_ADDRESS state
//  ld_state       in   1   FSM LOAD_DATA state
//  laf_state      in   1   FSM LOAD_AFTER_FULL state
//  full_state     in   1   FSM FIFO_FULL_STATE state
//  lfd_state      in   1   FSM LOAD_FIRST_DATA state
//  parity_done    out  1   parity byte has been captured/written
//  low_pkt_valid  out  1   pkt_valid fell during LOAD_DATA
//  err            out  1   parity mismatch
//  dout           out  8   byte to FIFO data input
// BEHAVIOUR
//  Reset: dout, parity_done, low_pkt_valid and err = 0.
//  Reset: internal header, full-hold, internal-parity and packet-parity registers = 0.
//  Reset has priority over all other updates.
//  Header reg: load data_in when detect_add & pkt_valid & data_in[1:0]!=2'b11; else hold.
//  Full-hold reg: load data_in when ld_state & fifo_full; else hold.
//  dout priority (registered, 1-cycle latency):
//    lfd_state -> header reg.
//    else ld_state & !fifo_full -> data_in.
//    else laf_state -> full-hold reg.
//    else hold.
//  low_pkt_valid:
//    rst_int_reg -> 0.
//    else ld_state & !pkt_valid -> 1.
//    else hold.
//  parity_done:
//    detect_add -> 0.
//    else (ld_state & !fifo_full & !pkt_valid) | (laf_state & low_pkt_valid & !parity_done) -> 1.
//    else hold.
//  internal parity:
//    detect_add -> 0.
//    else lfd_state & pkt_valid -> ^= header reg.
//    else ld_state & pkt_valid & !full_state -> ^= data_in.
//    else hold.
//  packet parity:
//    detect_add -> 0.
//    else ld_state & !pkt_valid -> data_in.
//    else hold.
//  err:
//    detect_add -> 0.
//    else parity_done -> (internal parity != packet parity).
//    else hold.
//    Valid the cycle after parity_done rises.
//  Simultaneous strobes: FSM guarantees one-hot states; with overlap, priority order above applies.
//  Reset mid-packet: all regs clear; the next packet must start with detect_add.
// CONFIGURATION
//  ROUTER_REG_PARITY_CHECK_EN defined: parity accumulation/compare as above.
//  Undefined: parity registers omitted; err tied 0; parity_done/low_pkt_valid/dout unchanged.
// STRUCTURE
//  router_pkg: DATA_WIDTH, ADDR_BITS, localparam ADDR_INVALID=2'b11, byte typedef.
//  router_pkg: the port list above is shared with router_fsm/router_fifo.
//  One sub-module: router_parity_chk (internal/packet parity regs and err compare).
//  router_parity_chk is instantiated only under ROUTER_REG_PARITY_CHECK_EN.
// TESTING
//  Reset: resetn=1 one cycle -> dout=0, parity_done=0, low_pkt_valid=0, err=0.
//  Good packet: detect_add+hdr 8'h14; lfd; ld with 8'h01,8'h02,8'h03; pkt_valid=0 with 8'h14
//    -> dout sequence 14,01,02,03,14; parity_done=1; err=0 next cycle.
//  Bad parity: same packet, parity byte 8'h15 -> err=1 one cycle after parity_done; cleared by next detect_add.
//  Invalid address: detect_add & pkt_valid with 8'h3F -> header reg unchanged; lfd dout shows previous header.
//  FIFO full: ld_state, fifo_full=1, data_in=8'hA5 -> dout holds.
//    Then full_state; laf_state, fifo_full=0 -> dout=8'hA5.
//  Late end: low_pkt_valid=1 in laf_state -> parity_done=1; rst_int_reg=1 -> low_pkt_valid=0.

Source files
------------

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the 1x3 packet router (router_reg,
// router_fsm, router_fifo).
//   DATA_WIDTH   : byte width of the packet datapath
//   ADDR_BITS    : header LSBs that carry the destination address
//   ADDR_INVALID : the one address code that does not name an output port
//   data_t       : one packet byte
//   addr_valid() : 1 when a header byte names a real output port
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_BITS  = 2;

  // Three output ports use codes 0..2; the all-ones code is unused.
  localparam logic [ADDR_BITS-1:0] ADDR_INVALID = '1;

  typedef logic [DATA_WIDTH-1:0] data_t;

  function automatic logic addr_valid(input data_t hdr);
    return (hdr[ADDR_BITS-1:0] != ADDR_INVALID);
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// ---------------------------------------------------------------------------
// router_reg_if
// Bundle of the signals between the router input port / FSM / FIFO side and
// the router_reg datapath.
//   pkt_valid, data_in, fifo_full : input-port and FIFO status
//   rst_int_reg, detect_add, ld_state, laf_state, full_state, lfd_state :
//                                   one-hot FSM state strobes
//   parity_done, low_pkt_valid, err, dout : results back to FSM / FIFO
// Handshake: there is no ready back-pressure on this bus. A byte on data_in is
// taken on the clock edge where pkt_valid and the matching FSM strobe are high;
// fifo_full is the only flow control and makes the datapath park the byte.
// modport master : the side that drives bytes and strobes (input port + FSM)
// modport slave  : router_reg
// ---------------------------------------------------------------------------
interface router_reg_if;
  import router_pkg::*;

  logic  pkt_valid;
  data_t data_in;
  logic  fifo_full;
  logic  rst_int_reg;
  logic  detect_add;
  logic  ld_state;
  logic  laf_state;
  logic  full_state;
  logic  lfd_state;
  logic  parity_done;
  logic  low_pkt_valid;
  logic  err;
  data_t dout;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg, detect_add,
           ld_state, laf_state, full_state, lfd_state,
    output parity_done, low_pkt_valid, err, dout
  );

endinterface

// File: rtl/router_parity_chk.sv
// ---------------------------------------------------------------------------
// router_parity_chk
// Accumulates even (XOR) parity over header and payload bytes, captures the
// packet's own parity byte, and raises o_err when the two disagree.
// Ports:
//   clock, resetn    : clock, synchronous active-high reset
//   i_detect_add     : start of packet, clears all parity state
//   i_lfd_state      : header is being written, fold header into parity
//   i_ld_state       : payload / parity byte phase
//   i_full_state     : FIFO-full wait, no accumulation
//   i_pkt_valid      : payload byte valid (low on the parity byte)
//   i_data_in        : incoming byte
//   i_hdr            : registered header byte
//   i_parity_done    : parity byte captured; triggers the compare
//   o_err            : registered parity mismatch flag
// ---------------------------------------------------------------------------
module router_parity_chk
  import router_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  i_detect_add,
  input  logic  i_lfd_state,
  input  logic  i_ld_state,
  input  logic  i_full_state,
  input  logic  i_pkt_valid,
  input  data_t i_data_in,
  input  data_t i_hdr,
  input  logic  i_parity_done,
  output logic  o_err
);

  data_t r_int_parity;
  data_t r_pkt_parity;
  logic  r_err;

  always_ff @(posedge clock) begin
    if (resetn) begin
      r_int_parity <= '0;
      r_pkt_parity <= '0;
      r_err        <= 1'b0;
    end else begin
      if (i_detect_add)
        r_int_parity <= '0;
      else if (i_lfd_state && i_pkt_valid)
        r_int_parity <= r_int_parity ^ i_hdr;
      else if (i_ld_state && i_pkt_valid && !i_full_state)
        r_int_parity <= r_int_parity ^ i_data_in;

      // The parity byte is the one presented with pkt_valid low.
      if (i_detect_add)
        r_pkt_parity <= '0;
      else if (i_ld_state && !i_pkt_valid)
        r_pkt_parity <= i_data_in;

      // parity_done is registered, so both parity regs are final when it
      // is seen high; err is therefore valid one cycle after it rises.
      if (i_detect_add)
        r_err <= 1'b0;
      else if (i_parity_done)
        r_err <= (r_int_parity != r_pkt_parity);
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/router_reg.sv
// ---------------------------------------------------------------------------
// router_reg
// Datapath register block of the 1x3 packet router. Sits between the input
// port and the output FIFOs and, under the FSM state strobes:
//   - latches the header byte (destination address in the low ADDR_BITS),
//   - registers header / payload / parity bytes onto the FIFO write data,
//   - parks a byte that arrives while the FIFO is full and replays it,
//   - tracks end of packet (low_pkt_valid) and parity byte capture,
//   - optionally checks packet parity and reports mismatch on err.
// Ports:
//   clock  : single clock, all state on posedge
//   resetn : synchronous reset, ACTIVE HIGH despite its name
//   bus    : router_reg_if.slave (strobes, data_in, fifo_full in;
//            dout, parity_done, low_pkt_valid, err out)
// Build option:
//   ROUTER_REG_PARITY_CHECK_EN defined   -> router_parity_chk instantiated
//   ROUTER_REG_PARITY_CHECK_EN undefined -> no parity registers, err tied 0
// ---------------------------------------------------------------------------
module router_reg
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  data_t r_hdr;
  data_t r_full_hold;
  data_t r_dout;
  logic  r_low_pkt_valid;
  logic  r_parity_done;

  always_ff @(posedge clock) begin
    if (resetn) begin
      r_hdr           <= '0;
      r_full_hold     <= '0;
      r_dout          <= '0;
      r_low_pkt_valid <= 1'b0;
      r_parity_done   <= 1'b0;
    end else begin
      // A header with the unused address code is ignored so a later
      // LOAD_FIRST_DATA still replays the last good header.
      if (bus.detect_add && bus.pkt_valid && addr_valid(bus.data_in))
        r_hdr <= bus.data_in;

      // Byte offered while the FIFO is full; replayed in LOAD_AFTER_FULL.
      if (bus.ld_state && bus.fifo_full)
        r_full_hold <= bus.data_in;

      if (bus.lfd_state)
        r_dout <= r_hdr;
      else if (bus.ld_state && !bus.fifo_full)
        r_dout <= bus.data_in;
      else if (bus.laf_state)
        r_dout <= r_full_hold;

      if (bus.rst_int_reg)
        r_low_pkt_valid <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        r_low_pkt_valid <= 1'b1;

      // Parity byte is done either when written directly in LOAD_DATA, or
      // when it was parked by a full FIFO and is replayed after the wait.
      if (bus.detect_add)
        r_parity_done <= 1'b0;
      else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
               (bus.laf_state && r_low_pkt_valid && !r_parity_done))
        r_parity_done <= 1'b1;
    end
  end

  assign bus.dout          = r_dout;
  assign bus.low_pkt_valid = r_low_pkt_valid;
  assign bus.parity_done   = r_parity_done;

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic w_err;

  router_parity_chk u_parity_chk (
    .clock         (clock),
    .resetn        (resetn),
    .i_detect_add  (bus.detect_add),
    .i_lfd_state   (bus.lfd_state),
    .i_ld_state    (bus.ld_state),
    .i_full_state  (bus.full_state),
    .i_pkt_valid   (bus.pkt_valid),
    .i_data_in     (bus.data_in),
    .i_hdr         (r_hdr),
    .i_parity_done (r_parity_done),
    .o_err         (w_err)
  );

  assign bus.err = w_err;
`else
  // full_state only matters to the parity accumulator.
  logic w_unused_full_state;
  assign w_unused_full_state = bus.full_state;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// ---------------------------------------------------------------------------
// tb_router_reg
// Directed, table-driven bench for router_reg. Each table row is one clock:
// strobes and data are applied, the edge is taken, and dout / parity_done /
// low_pkt_valid / err are compared on the following falling edge.
// err expectations assume the parity checker; without
// ROUTER_REG_PARITY_CHECK_EN err is expected to stay 0.
// ---------------------------------------------------------------------------
module tb_router_reg;
  import router_pkg::*;

`ifdef ROUTER_REG_PARITY_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Control word bits: {rst, det, lfd, ld, laf, full, rint}
  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b1000000;
  localparam logic [6:0] C_DET  = 7'b0100000;
  localparam logic [6:0] C_LFD  = 7'b0010000;
  localparam logic [6:0] C_LD   = 7'b0001000;
  localparam logic [6:0] C_LAF  = 7'b0000100;
  localparam logic [6:0] C_FULL = 7'b0000010;
  localparam logic [6:0] C_RINT = 7'b0000001;

  typedef struct {
    logic [6:0] ctl;
    logic       pv;
    logic       ff;
    data_t      din;
    data_t      e_dout;
    logic       e_pd;
    logic       e_lpv;
    logic       e_err;
  } vec_t;

  localparam int NVEC = 29;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_errors;
  vec_t vecs [NVEC];

  router_reg_if bus ();

  router_reg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver ----------------
  task automatic drive(input logic [6:0] ctl, input logic pv, input logic ff,
                       input data_t din);
    resetn          = ctl[6];
    bus.detect_add  = ctl[5];
    bus.lfd_state   = ctl[4];
    bus.ld_state    = ctl[3];
    bus.laf_state   = ctl[2];
    bus.full_state  = ctl[1];
    bus.rst_int_reg = ctl[0];
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.data_in     = din;
  endtask

  task automatic step(input logic [6:0] ctl, input logic pv, input logic ff,
                      input data_t din);
    drive(ctl, pv, ff, din);
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- checker ----------------
  task automatic check(input string name, input int idx, input data_t act,
                       input data_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input data_t e_dout, input logic e_pd,
                           input logic e_lpv, input logic e_err);
    check("dout",          idx, bus.dout, e_dout);
    check("parity_done",   idx, data_t'(bus.parity_done),   data_t'(e_pd));
    check("low_pkt_valid", idx, data_t'(bus.low_pkt_valid), data_t'(e_lpv));
    check("err",           idx, data_t'(bus.err),           data_t'(e_err & ERR_EN));
  endtask

  function automatic vec_t mk(input logic [6:0] ctl, input logic pv,
                              input logic ff, input data_t din,
                              input data_t e_dout, input logic e_pd,
                              input logic e_lpv, input logic e_err);
    vec_t v;
    v.ctl = ctl; v.pv = pv; v.ff = ff; v.din = din;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(C_IDLE, 1'b0, 1'b0, 8'h00);
    resetn = 1'b1;

    //                ctl            pv    ff    din    dout  pd    lpv   err
    // reset
    vecs[0]  = mk(C_RST,          1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // good packet: hdr 14, payload 01 02 03, parity 14
    vecs[1]  = mk(C_DET,          1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(C_LFD,          1'b1, 1'b0, 8'h01, 8'h14, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(C_LD,           1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(C_LD,           1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(C_LD,           1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(C_LD,           1'b0, 1'b0, 8'h14, 8'h14, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(C_IDLE,         1'b0, 1'b0, 8'h00, 8'h14, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(C_RINT,         1'b0, 1'b0, 8'h00, 8'h14, 1'b1, 1'b0, 1'b0);
    // bad parity: same packet, parity byte 15
    vecs[9]  = mk(C_DET,          1'b1, 1'b0, 8'h14, 8'h14, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(C_LFD,          1'b1, 1'b0, 8'h01, 8'h14, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(C_LD,           1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(C_LD,           1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(C_LD,           1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(C_LD,           1'b0, 1'b0, 8'h15, 8'h15, 1'b1, 1'b1, 1'b0);
    vecs[15] = mk(C_IDLE,         1'b0, 1'b0, 8'h00, 8'h15, 1'b1, 1'b1, 1'b1);
    vecs[16] = mk(C_IDLE,         1'b0, 1'b0, 8'h00, 8'h15, 1'b1, 1'b1, 1'b1);
    // invalid address 3F: header stays 14, err/parity_done cleared
    vecs[17] = mk(C_DET,          1'b1, 1'b0, 8'h3F, 8'h15, 1'b0, 1'b1, 1'b0);
    vecs[18] = mk(C_LFD,          1'b1, 1'b0, 8'h00, 8'h14, 1'b0, 1'b1, 1'b0);
    vecs[19] = mk(C_RINT,         1'b0, 1'b0, 8'h00, 8'h14, 1'b0, 1'b0, 1'b0);
    // FIFO full: A5 parked, full-state byte not accumulated, replayed in laf
    vecs[20] = mk(C_LD,           1'b1, 1'b1, 8'hA5, 8'h14, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(C_FULL,         1'b1, 1'b1, 8'h5A, 8'h14, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(C_LAF,          1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(C_LD,           1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
    // late end: parity byte A1 (=14^A5^10) arrives with FIFO full
    vecs[24] = mk(C_LD,           1'b0, 1'b1, 8'hA1, 8'h10, 1'b0, 1'b1, 1'b0);
    vecs[25] = mk(C_LAF,          1'b0, 1'b0, 8'h00, 8'hA1, 1'b1, 1'b1, 1'b0);
    vecs[26] = mk(C_IDLE,         1'b0, 1'b0, 8'h00, 8'hA1, 1'b1, 1'b1, 1'b0);
    vecs[27] = mk(C_RINT,         1'b0, 1'b0, 8'h00, 8'hA1, 1'b1, 1'b0, 1'b0);
    // reset mid-state clears everything
    vecs[28] = mk(C_RST | C_LD,   1'b0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].ctl, vecs[i].pv, vecs[i].ff, vecs[i].din);
      check_all(i, vecs[i].e_dout, vecs[i].e_pd, vecs[i].e_lpv, vecs[i].e_err);
    end

    // Overlapping strobes: lfd beats ld; header load needs pkt_valid.
    step(C_DET, 1'b1, 1'b0, 8'h2A);
    check_all(100, 8'h00, 1'b0, 1'b0, 1'b0);
    step(C_LFD | C_LD, 1'b1, 1'b0, 8'h77);
    check_all(101, 8'h2A, 1'b0, 1'b0, 1'b0);
    step(C_DET, 1'b0, 1'b0, 8'h55);
    check_all(102, 8'h2A, 1'b0, 1'b0, 1'b0);
    step(C_LFD, 1'b1, 1'b0, 8'h00);
    check_all(103, 8'h2A, 1'b0, 1'b0, 1'b0);
    // ld with FIFO free beats laf.
    step(C_LD | C_LAF, 1'b1, 1'b0, 8'h3C);
    check_all(104, 8'h3C, 1'b0, 1'b0, 1'b0);
    // rst_int_reg beats ld & !pkt_valid for low_pkt_valid; parity_done still sets.
    step(C_LD | C_RINT, 1'b0, 1'b0, 8'h16);
    check_all(105, 8'h16, 1'b1, 1'b0, 1'b0);
    // hdr 2A: parity 2A^3C = 16 matches, err stays 0.
    step(C_IDLE, 1'b0, 1'b0, 8'h00);
    check_all(106, 8'h16, 1'b1, 1'b0, 1'b0);

    drive(C_IDLE, 1'b0, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
